vexriscv_bus_arbiter: RTL and testbench

//   Shares one single-port memory between the VexRiscv iBus (fetch) and dBus (load/store) in the

---
 rtl/vexriscv_arb_pkg.sv | 23 ++
 rtl/vexriscv_arb_tag_fifo.sv | 68 ++++++
 rtl/vexriscv_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_vexriscv_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vexriscv_arb_pkg.sv
// Shared types and helpers for the VexRiscv iBus/dBus memory arbiter.
// Holds the source tag, access-size codes and the store byte-enable function.
package vexriscv_arb_pkg;

  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Size 3 is not a legal RISC-V access; treat it as a full word.
  function automatic logic [3:0] wstrb_f(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << addr_lo;
      SZ_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
      SZ_WORD: strb = 4'b1111;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/vexriscv_arb_tag_fifo.sv
// In-order FIFO of 1-bit source tags, one entry per outstanding read.
// Count is one bit wider than the pointers so full and empty never alias.
module vexriscv_arb_tag_fifo
  import vexriscv_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  src_e                     push_tag,
  input  logic                     pop,
  output src_e                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  src_e            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push_ok_s, pop_ok_s;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= SRC_I;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_tag;
      end
    end
  end

endmodule

// File: rtl/vexriscv_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between VexRiscv iBus and dBus.
// Grant is locked across memory stalls; read responses are routed back by an in-order tag FIFO.
module vexriscv_bus_arbiter
  import vexriscv_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit DBUS_FIRST      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iBus_cmd_valid,
  output logic        iBus_cmd_ready,
  input  logic [31:0] iBus_cmd_payload_pc,
  output logic        iBus_rsp_ready,
  output logic [31:0] iBus_rsp_inst,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic [31:0] dBus_rsp_data,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_cmd_addr,
  output logic        mem_cmd_wr,
  output logic [31:0] mem_cmd_wdata,
  output logic [3:0]  mem_cmd_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        protocol_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  // last_winner starts as the loser so the preferred source wins the first tie.
  localparam src_e RR_INIT = DBUS_FIRST ? SRC_I : SRC_D;

  logic          lock_q, lock_d;
  src_e          lock_src_q, lock_src_d;
  src_e          last_winner_q, last_winner_d;
  logic          protocol_err_q, protocol_err_d;

  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s, fifo_empty_s;
  src_e          fifo_head_s;
  logic          slot_free_s, i_elig_s, d_elig_s;
  logic          grant_vld_s, hs_s, push_s, pop_s;
  src_e          grant_src_s;

  vexriscv_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_s),
    .push_tag (grant_src_s),
    .pop      (pop_s),
    .head     (fifo_head_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // A response popping this cycle does not free its slot until the next cycle.
  assign slot_free_s = (fifo_count_s < CW'(MAX_OUTSTANDING));
  assign i_elig_s    = iBus_cmd_valid && slot_free_s;
  assign d_elig_s    = dBus_cmd_valid && (dBus_cmd_payload_wr || slot_free_s);

  always_comb begin
    grant_vld_s = 1'b0;
    grant_src_s = SRC_I;
    if (reset) begin
      grant_vld_s = 1'b0;
    end else if (lock_q) begin
      grant_vld_s = 1'b1;
      grant_src_s = lock_src_q;
    end else if (i_elig_s && d_elig_s) begin
      grant_vld_s = 1'b1;
      grant_src_s = (last_winner_q == SRC_I) ? SRC_D : SRC_I;
    end else if (d_elig_s) begin
      grant_vld_s = 1'b1;
      grant_src_s = SRC_D;
    end else if (i_elig_s) begin
      grant_vld_s = 1'b1;
      grant_src_s = SRC_I;
    end else begin
      grant_vld_s = 1'b0;
    end
  end

  always_comb begin
    mem_cmd_addr  = iBus_cmd_payload_pc;
    mem_cmd_wr    = 1'b0;
    mem_cmd_wdata = 32'h0000_0000;
    mem_cmd_wstrb = 4'h0;
    if (grant_src_s == SRC_D) begin
      mem_cmd_addr  = dBus_cmd_payload_address;
      mem_cmd_wr    = dBus_cmd_payload_wr;
      mem_cmd_wdata = dBus_cmd_payload_data;
      mem_cmd_wstrb = dBus_cmd_payload_wr ?
                      wstrb_f(dBus_cmd_payload_size, dBus_cmd_payload_address[1:0]) : 4'h0;
    end else begin
      mem_cmd_addr  = iBus_cmd_payload_pc;
    end
  end

  assign mem_cmd_valid  = grant_vld_s;
  assign hs_s           = grant_vld_s && mem_cmd_ready;
  assign iBus_cmd_ready = hs_s && (grant_src_s == SRC_I);
  assign dBus_cmd_ready = hs_s && (grant_src_s == SRC_D);
  assign push_s         = hs_s && !fifo_full_s && !((grant_src_s == SRC_D) && dBus_cmd_payload_wr);

  assign pop_s          = mem_rsp_valid && !fifo_empty_s && !reset;
  assign iBus_rsp_ready = pop_s && (fifo_head_s == SRC_I);
  assign dBus_rsp_ready = pop_s && (fifo_head_s == SRC_D);
  assign iBus_rsp_inst  = mem_rsp_rdata;
  assign dBus_rsp_data  = mem_rsp_rdata;
  assign protocol_err   = protocol_err_q;

  always_comb begin
    lock_d         = lock_q;
    lock_src_d     = lock_src_q;
    last_winner_d  = last_winner_q;
    protocol_err_d = protocol_err_q;
    if (hs_s) begin
      lock_d        = 1'b0;
      last_winner_d = grant_src_s;
    end else if (grant_vld_s) begin
      lock_d     = 1'b1;
      lock_src_d = grant_src_s;
    end else begin
      lock_d = lock_q;
    end
    if (mem_rsp_valid && fifo_empty_s) begin
      protocol_err_d = 1'b1;
    end else begin
      protocol_err_d = protocol_err_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q         <= 1'b0;
      lock_src_q     <= SRC_I;
      last_winner_q  <= RR_INIT;
      protocol_err_q <= 1'b0;
    end else begin
      lock_q         <= lock_d;
      lock_src_q     <= lock_src_d;
      last_winner_q  <= last_winner_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_vexriscv_bus_arbiter.sv
// Directed bench for vexriscv_bus_arbiter: drives on negedge, checks 1 time unit later,
// and predicts response routing with a queue of expected source tags.
module tb_vexriscv_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        iBus_cmd_valid, iBus_cmd_ready, iBus_rsp_ready;
  logic [31:0] iBus_cmd_payload_pc, iBus_rsp_inst;
  logic        dBus_cmd_valid, dBus_cmd_ready, dBus_cmd_payload_wr, dBus_rsp_ready;
  logic [31:0] dBus_cmd_payload_address, dBus_cmd_payload_data, dBus_rsp_data;
  logic [1:0]  dBus_cmd_payload_size;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr, mem_rsp_valid, protocol_err;
  logic [31:0] mem_cmd_addr, mem_cmd_wdata, mem_rsp_rdata;
  logic [3:0]  mem_cmd_wstrb;

  int checks = 0;
  int errors = 0;
  bit sb [$];

  always #5 clock = ~clock;

  vexriscv_bus_arbiter #(.MAX_OUTSTANDING(4), .DBUS_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset),
    .iBus_cmd_valid(iBus_cmd_valid), .iBus_cmd_ready(iBus_cmd_ready),
    .iBus_cmd_payload_pc(iBus_cmd_payload_pc),
    .iBus_rsp_ready(iBus_rsp_ready), .iBus_rsp_inst(iBus_rsp_inst),
    .dBus_cmd_valid(dBus_cmd_valid), .dBus_cmd_ready(dBus_cmd_ready),
    .dBus_cmd_payload_wr(dBus_cmd_payload_wr),
    .dBus_cmd_payload_address(dBus_cmd_payload_address),
    .dBus_cmd_payload_data(dBus_cmd_payload_data),
    .dBus_cmd_payload_size(dBus_cmd_payload_size),
    .dBus_rsp_ready(dBus_rsp_ready), .dBus_rsp_data(dBus_rsp_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_wstrb(mem_cmd_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Payload must hold while the memory stalls a request.
  logic        stall_prev = 1'b0;
  logic [31:0] addr_prev  = 32'h0;
  always @(negedge clock) begin
    #3;
    if (stall_prev) begin
      chk("stall_valid_hold", {31'h0, mem_cmd_valid}, 32'h1);
      chk("stall_addr_hold", mem_cmd_addr, addr_prev);
    end
    stall_prev = mem_cmd_valid && !mem_cmd_ready && !reset;
    addr_prev  = mem_cmd_addr;
  end

  task automatic idle();
    @(negedge clock);
    iBus_cmd_valid = 1'b0;
    dBus_cmd_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    @(negedge clock);
    iBus_cmd_valid = 1'b1;
    dBus_cmd_valid = 1'b0;
    iBus_cmd_payload_pc = pc;
    #1;
    chk("fetch_ready", {31'h0, iBus_cmd_ready}, 32'h1);
    chk("fetch_addr", mem_cmd_addr, pc);
    sb.push_back(1'b0);
  endtask

  task automatic rsp(input logic [31:0] data);
    bit exp_d;
    @(negedge clock);
    iBus_cmd_valid = 1'b0;
    dBus_cmd_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = data;
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 32'h1, 32'h0);
    end else begin
      exp_d = sb.pop_front();
      chk("rsp_i_strobe", {31'h0, iBus_rsp_ready}, {31'h0, !exp_d});
      chk("rsp_d_strobe", {31'h0, dBus_rsp_ready}, {31'h0, exp_d});
      chk("rsp_inst", iBus_rsp_inst, data);
      chk("rsp_data", dBus_rsp_data, data);
    end
    @(negedge clock);
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    bit exp_d;
    reset = 1'b1;
    mem_cmd_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    iBus_cmd_valid = 1'b1;
    iBus_cmd_payload_pc = 32'h0000_0010;
    dBus_cmd_valid = 1'b1;
    dBus_cmd_payload_wr = 1'b1;
    dBus_cmd_payload_address = 32'h0000_0020;
    dBus_cmd_payload_data = 32'h1122_3344;
    dBus_cmd_payload_size = 2'd2;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset_mem_valid", {31'h0, mem_cmd_valid}, 32'h0);
    chk("reset_i_ready", {31'h0, iBus_cmd_ready}, 32'h0);
    chk("reset_d_ready", {31'h0, dBus_cmd_ready}, 32'h0);
    chk("reset_rsp", {30'h0, iBus_rsp_ready, dBus_rsp_ready}, 32'h0);
    chk("reset_perr", {31'h0, protocol_err}, 32'h0);

    // 1: strict alternation starting with dBus (dBus issues stores)
    exp_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rr_i_ready", {31'h0, iBus_cmd_ready}, {31'h0, !exp_d});
      chk("rr_d_ready", {31'h0, dBus_cmd_ready}, {31'h0, exp_d});
      chk("rr_addr", mem_cmd_addr, exp_d ? 32'h0000_0020 : 32'h0000_0010);
      chk("rr_wstrb", {28'h0, mem_cmd_wstrb}, exp_d ? 32'hF : 32'h0);
      if (!exp_d) sb.push_back(1'b0);
      exp_d = !exp_d;
    end
    idle();
    rsp(32'h0000_0001);
    rsp(32'h0000_0002);

    // 2: grant locks on iBus through a 3-cycle stall, then dBus load
    @(negedge clock);
    iBus_cmd_valid = 1'b1;
    iBus_cmd_payload_pc = 32'h0000_0100;
    mem_cmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      if (k == 1) begin
        dBus_cmd_valid = 1'b1;
        dBus_cmd_payload_wr = 1'b0;
        dBus_cmd_payload_address = 32'h0000_0200;
      end
      #1;
      chk("lock_valid", {31'h0, mem_cmd_valid}, 32'h1);
      chk("lock_addr", mem_cmd_addr, 32'h0000_0100);
      chk("lock_readys", {30'h0, iBus_cmd_ready, dBus_cmd_ready}, 32'h0);
    end
    @(negedge clock);
    mem_cmd_ready = 1'b1;
    #1;
    chk("lock_release_i", {30'h0, iBus_cmd_ready, dBus_cmd_ready}, 32'h2);
    chk("lock_release_addr", mem_cmd_addr, 32'h0000_0100);
    sb.push_back(1'b0);
    @(negedge clock);
    #1;
    chk("after_lock_d", {30'h0, iBus_cmd_ready, dBus_cmd_ready}, 32'h1);
    chk("after_lock_addr", mem_cmd_addr, 32'h0000_0200);
    chk("load_wstrb", {28'h0, mem_cmd_wstrb}, 32'h0);
    chk("load_wr", {31'h0, mem_cmd_wr}, 32'h0);
    sb.push_back(1'b1);
    idle();
    rsp(32'h0000_100A);
    rsp(32'h0000_200B);

    // 3: three fetches and one load, responses in order
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_0008);
    @(negedge clock);
    iBus_cmd_valid = 1'b0;
    dBus_cmd_valid = 1'b1;
    dBus_cmd_payload_address = 32'h0000_0300;
    #1;
    chk("t3_load_ready", {31'h0, dBus_cmd_ready}, 32'h1);
    sb.push_back(1'b1);
    rsp(32'h0000_000A);
    rsp(32'h0000_000B);
    rsp(32'h0000_000C);
    rsp(32'h0000_000D);

    // 4: FIFO full; a pop in the same cycle does not free a slot for the load
    for (int k = 0; k < 4; k++) fetch(32'h0000_0040 + 32'(k * 4));
    @(negedge clock);
    iBus_cmd_valid = 1'b0;
    dBus_cmd_valid = 1'b1;
    dBus_cmd_payload_wr = 1'b0;
    dBus_cmd_payload_address = 32'h0000_0400;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0E00;
    #1;
    chk("full_load_blocked", {30'h0, mem_cmd_valid, dBus_cmd_ready}, 32'h0);
    exp_d = sb.pop_front();
    chk("full_pop_i", {30'h0, iBus_rsp_ready, dBus_rsp_ready}, exp_d ? 32'h1 : 32'h2);
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    #1;
    chk("full_load_next", {31'h0, dBus_cmd_ready}, 32'h1);
    sb.push_back(1'b1);
    idle();
    rsp(32'h0000_0E01);
    rsp(32'h0000_0E02);
    rsp(32'h0000_0E03);
    rsp(32'h0000_0E04);

    // 5: narrow stores issue while the FIFO is full
    for (int k = 0; k < 4; k++) fetch(32'h0000_0080 + 32'(k * 4));
    @(negedge clock);
    iBus_cmd_valid = 1'b0;
    dBus_cmd_valid = 1'b1;
    dBus_cmd_payload_wr = 1'b1;
    dBus_cmd_payload_size = 2'd0;
    dBus_cmd_payload_address = 32'h0000_1003;
    dBus_cmd_payload_data = 32'hAAAA_AAAA;
    #1;
    chk("sb_ready", {31'h0, dBus_cmd_ready}, 32'h1);
    chk("sb_wstrb", {28'h0, mem_cmd_wstrb}, 32'h8);
    chk("sb_wdata", mem_cmd_wdata, 32'hAAAA_AAAA);
    @(negedge clock);
    dBus_cmd_payload_size = 2'd1;
    dBus_cmd_payload_address = 32'h0000_1002;
    #1;
    chk("sh_ready", {31'h0, dBus_cmd_ready}, 32'h1);
    chk("sh_wstrb", {28'h0, mem_cmd_wstrb}, 32'hC);
    chk("sh_wr", {31'h0, mem_cmd_wr}, 32'h1);
    idle();
    rsp(32'h0000_0F01);
    rsp(32'h0000_0F02);
    rsp(32'h0000_0F03);
    rsp(32'h0000_0F04);

    // 6: unsolicited response sets the sticky error; reset clears it
    @(negedge clock);
    mem_rsp_valid = 1'b1;
    #1;
    chk("err_no_strobe", {30'h0, iBus_rsp_ready, dBus_rsp_ready}, 32'h0);
    chk("err_not_yet", {31'h0, protocol_err}, 32'h0);
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    #1;
    chk("err_set", {31'h0, protocol_err}, 32'h1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("err_cleared", {31'h0, protocol_err}, 32'h0);

    // Reset with a fetch outstanding: the late response is unsolicited
    fetch(32'h0000_0500);
    void'(sb.pop_back());
    idle();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    #1;
    chk("late_no_strobe", {30'h0, iBus_rsp_ready, dBus_rsp_ready}, 32'h0);
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    #1;
    chk("late_err", {31'h0, protocol_err}, 32'h1);
    chk("sb_drained", sb.size(), 32'h0);

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
